// File: rtl/hsst_tx_framer_32bit_pkg.sv
// Shared constants and encodings for the HSST 32-bit transmit framer:
// K-code idle pattern, per-byte K flags, FSM and write-side mode encodings.
package hsst_tx_framer_32bit_pkg;

  localparam logic [7:0]  K28_5     = 8'hBC;
  localparam logic [31:0] IDLE_WORD = {4{K28_5}};
  localparam logic [3:0]  TXK_IDLE  = 4'b1111;
  localparam logic [3:0]  TXK_DATA  = 4'b0000;

  // Transmit state machine encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_e;

  // Write side: normal buffering, or discarding the rest of an oversize frame.
  typedef enum logic {
    WR_PASS = 1'b0,
    WR_DROP = 1'b1
  } wr_mode_e;

  // One buffer entry: frame-end marker above the payload word.
  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } fifo_word_t;

  // Idle-word counter step, saturating at 15.
  function automatic logic [3:0] gap_inc(input logic [3:0] cnt);
    return (cnt == 4'd15) ? cnt : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/hsst_tx_framer_32bit_fifo.sv
// hsst_tx_frame_fifo: synchronous first-word-fall-through frame buffer with
// full/empty flags and a flush input that empties it in one cycle.
module hsst_tx_frame_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_fire, rd_fire;

  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign wr_fire   = wr_en_i && !full_o && !flush_i;
  assign rd_fire   = rd_en_i && !empty_o && !flush_i;
  // Head word is always visible without a read request.
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update: flush wins over any push or pop in the same cycle.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (rd_fire) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage write.
  // NOTE: the array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/hsst_tx_framer_32bit.sv
// hsst_tx_framer_32bit: store-and-forward framer feeding a 32-bit HSST
// transmitter. Frames are buffered whole, then sent back-to-back with
// tx_k=0000, separated by at least MIN_GAP K28.5 idle words.
// Oversize frames (buffer full with no complete frame) set a sticky error,
// flush the buffer and are discarded through their last word.
// Optional feature: define HSST_TX_FRAMER_STATS_EN to enable the
// frame_cnt / word_cnt statistics; otherwise both outputs are tied to 0.
module hsst_tx_framer_32bit
  import hsst_tx_framer_32bit_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int MIN_GAP    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic [31:0] tx_data,
  output logic [3:0]  tx_k,
  output logic        busy,
  output logic        err_oversize,
  output logic [15:0] frame_cnt,
  output logic [31:0] word_cnt
);

  // Pending count can reach one frame per buffer entry.
  localparam int         PW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] GAP_MIN  = 4'(MIN_GAP);
  localparam logic [3:0] GAP_LAST = 4'(MIN_GAP - 1);

  fifo_word_t  fifo_wr_word, fifo_rd_word;
  logic        fifo_wr_en, fifo_rd_en, fifo_flush;
  logic        fifo_full, fifo_empty;

  wr_mode_e    wr_mode_q, wr_mode_d;
  logic        err_q;
  logic        oversize;
  logic        wr_last, rd_last;
  logic [PW-1:0] pending_q, pending_d;

  tx_state_e   state_q, state_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [31:0] tx_data_q, tx_data_d;
  logic [3:0]  tx_k_q, tx_k_d;
  logic        pop;

  assign fifo_wr_word = '{last: s_last, data: s_data};

  hsst_tx_frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (33)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush_i   (fifo_flush),
    .wr_en_i   (fifo_wr_en),
    .wr_data_i (fifo_wr_word),
    .rd_en_i   (fifo_rd_en),
    .rd_data_o (fifo_rd_word),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // A full buffer holding no complete frame can never drain: treat as oversize.
  assign oversize = (wr_mode_q == WR_PASS) && fifo_full && (pending_q == '0);

  // Write side: accept, flush on oversize, or discard through the next last word.
  // NOTE: every signal gets a default at the top of a combinational block so no latch is inferred.
  always_comb begin
    wr_mode_d  = wr_mode_q;
    fifo_flush = 1'b0;
    fifo_wr_en = 1'b0;
    s_ready    = (wr_mode_q == WR_DROP) ? 1'b1 : !fifo_full;
    if (wr_mode_q == WR_DROP) begin
      if (s_valid && s_last) wr_mode_d = WR_PASS;
    end else if (oversize) begin
      fifo_flush = 1'b1;
      wr_mode_d  = WR_DROP;
    end else begin
      fifo_wr_en = s_valid && !fifo_full;
    end
  end

  // Complete frames in the buffer: +1 per written last word, -1 per popped one.
  assign wr_last = fifo_wr_en && s_last;
  assign rd_last = fifo_rd_en && fifo_rd_word.last;

  always_comb begin
    pending_d = pending_q;
    if (fifo_flush) begin
      pending_d = '0;
    end else begin
      case ({wr_last, rd_last})
        2'b10:   pending_d = pending_q + PW'(1);
        2'b01:   pending_d = pending_q - PW'(1);
        default: pending_d = pending_q;
      endcase
    end
  end

  // Write-side registers: drop mode, sticky error, pending frame count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_mode_q <= WR_PASS;
      err_q     <= 1'b0;
      pending_q <= '0;
    end else begin
      wr_mode_q <= wr_mode_d;
      err_q     <= err_q | oversize;
      pending_q <= pending_d;
    end
  end

  // Transmit FSM: choose the next output word and the next state.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    tx_data_d = IDLE_WORD;
    tx_k_d    = TXK_IDLE;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((pending_q != '0) && (gap_cnt_q >= GAP_MIN)) pop = 1'b1;
        else gap_cnt_d = gap_inc(gap_cnt_q);
      end
      ST_SEND: pop = !fifo_empty;
      ST_GAP: begin
        gap_cnt_d = gap_inc(gap_cnt_q);
        if (gap_cnt_q >= GAP_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop) begin
      tx_data_d = fifo_rd_word.data;
      tx_k_d    = TXK_DATA;
      if (fifo_rd_word.last) begin
        state_d   = ST_GAP;
        gap_cnt_d = '0;
      end else begin
        state_d   = ST_SEND;
      end
    end
  end

  assign fifo_rd_en = pop;

  // Transmit registers: state, idle counter and the registered line outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= '0;
      tx_data_q <= IDLE_WORD;
      tx_k_q    <= TXK_IDLE;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      tx_data_q <= tx_data_d;
      tx_k_q    <= tx_k_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_k         = tx_k_q;
  assign busy         = (state_q == ST_SEND);
  assign err_oversize = err_q;

`ifdef HSST_TX_FRAMER_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [31:0] word_cnt_q;

  // Statistics: every popped word is transmitted; a popped last word ends a frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt_q <= '0;
      word_cnt_q  <= '0;
    end else if (fifo_rd_en) begin
      word_cnt_q <= word_cnt_q + 32'd1;
      if (fifo_rd_word.last) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign word_cnt  = word_cnt_q;
`else
  assign frame_cnt = '0;
  assign word_cnt  = '0;
`endif

endmodule

// File: tb/tb_hsst_tx_framer_32bit.sv
// Testbench for hsst_tx_framer_32bit: directed frame scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// queue-based behavioural model of the framer.
module tb_hsst_tx_framer_32bit;

  localparam int          FIFO_DEPTH = 64;
  localparam int          MIN_GAP    = 2;
  localparam logic [31:0] IDLE       = 32'hBCBCBCBC;
  localparam int          BUDGET     = 500;
`ifdef HSST_TX_FRAMER_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic [31:0] tx_data;
  logic [3:0]  tx_k;
  logic        busy;
  logic        err_oversize;
  logic [15:0] frame_cnt;
  logic [31:0] word_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  hsst_tx_framer_32bit #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .MIN_GAP    (MIN_GAP)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .tx_data      (tx_data),
    .tx_k         (tx_k),
    .busy         (busy),
    .err_oversize (err_oversize),
    .frame_cnt    (frame_cnt),
    .word_cnt     (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } word_t;

  word_t       m_q[$];          // buffered words, oldest first
  bit          m_in_frame = 1'b0;
  bit          m_drop = 1'b0;
  bit          m_err = 1'b0;
  int          m_idle_run = 0;  // idle words emitted since the last data word or reset
  logic [31:0] m_tx_data = IDLE;
  logic [3:0]  m_tx_k = 4'hF;
  logic [15:0] m_frames = '0;
  logic [31:0] m_words = '0;
  int          m_npend;
  bit          m_full;
  word_t       m_ent;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_q.delete();
      m_in_frame = 1'b0;
      m_drop     = 1'b0;
      m_err      = 1'b0;
      m_idle_run = 0;
      m_tx_data  = IDLE;
      m_tx_k     = 4'hF;
      m_frames   = '0;
      m_words    = '0;
    end else begin
      m_npend = 0;
      foreach (m_q[i]) if (m_q[i].last) m_npend++;
      m_full = (m_q.size() == FIFO_DEPTH);
      // Output: continue a frame, or start one once a whole frame is buffered
      // and enough idles have gone out.
      if (m_in_frame || (m_npend > 0 && m_idle_run >= MIN_GAP)) begin
        m_ent      = m_q.pop_front();
        m_tx_data  = m_ent.data;
        m_tx_k     = 4'h0;
        m_in_frame = !m_ent.last;
        m_words    = m_words + 32'd1;
        if (m_ent.last) begin
          m_frames   = m_frames + 16'd1;
          m_idle_run = 0;
        end
      end else begin
        m_tx_data = IDLE;
        m_tx_k    = 4'hF;
        if (m_idle_run < 1000) m_idle_run++;
      end
      // Input side.
      if (m_drop) begin
        if (s_valid && s_last) m_drop = 1'b0;
      end else if (m_full && m_npend == 0) begin
        m_q.delete();
        m_err  = 1'b1;
        m_drop = 1'b1;
      end else if (s_valid && !m_full) begin
        m_q.push_back('{last: s_last, data: s_data});
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("tx_data", tx_data, m_tx_data);
      check("tx_k", tx_k, m_tx_k);
      check("busy", busy, m_in_frame);
      check("err_oversize", err_oversize, m_err);
      check("s_ready", s_ready, m_drop ? 1'b1 : (m_q.size() != FIFO_DEPTH));
      check("frame_cnt", frame_cnt, STATS_ON ? m_frames : 16'd0);
      check("word_cnt", word_cnt, STATS_ON ? m_words : 32'd0);
    end
  end

  // Output trace for the literal scenario checks.
  logic [35:0] trace[$];
  always @(negedge clk) begin
    if (rstn) trace.push_back({tx_k, tx_data});
  end

  function automatic int find_data(input logic [31:0] d);
    for (int i = 0; i < trace.size(); i++)
      if (trace[i][35:32] == 4'h0 && trace[i][31:0] == d) return i;
    return -1;
  endfunction

  function automatic logic [35:0] get(input int i);
    if (i < 0 || i >= trace.size()) return '0;
    return trace[i];
  endfunction

  function automatic int count_data();
    int n = 0;
    foreach (trace[i]) if (trace[i][35:32] == 4'h0) n++;
    return n;
  endfunction

  // ---------------- drivers (start and end at posedge+1) ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, input int pre_idle);
    bit acc = 1'b0;
    int n = 0;
    for (int i = 0; i < pre_idle; i++) begin
      s_valid = 1'b0;
      wait_cycles(1);
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!acc && n < BUDGET) begin
      @(negedge clk);
      acc = s_ready;
      wait_cycles(1);
      n++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("handshake", acc, 1'b1);
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    s_last  = 1'b0;
    rstn    = 1'b0;
    #1;
    check("rst_tx_data", tx_data, IDLE);
    check("rst_tx_k", tx_k, 4'hF);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_oversize, 1'b0);
    check("rst_frame_cnt", frame_cnt, 16'd0);
    check("rst_word_cnt", word_cnt, 32'd0);
    check("rst_s_ready", s_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    trace.delete();
  endtask

  int idx, i1, i2;
  bit found;

  initial begin
    #2;
    do_reset();
    cmp_en = 1'b1;

    // 3-word frame after reset.
    send_word(32'h11111111, 1'b0, 0);
    send_word(32'h22222222, 1'b0, 0);
    send_word(32'h33333333, 1'b1, 0);
    wait_cycles(15);
    idx = find_data(32'h11111111);
    check("f3_pre_idles_ge2", idx >= 2, 1'b1);
    check("f3_w0", get(idx),     {4'h0, 32'h11111111});
    check("f3_w1", get(idx + 1), {4'h0, 32'h22222222});
    check("f3_w2", get(idx + 2), {4'h0, 32'h33333333});
    check("f3_post_idle", get(idx + 3), {4'hF, IDLE});

    // Two back-to-back 1-word frames: exactly MIN_GAP idles between.
    do_reset();
    send_word(32'hAAAA0001, 1'b1, 0);
    send_word(32'hAAAA0002, 1'b1, 0);
    wait_cycles(15);
    i1 = find_data(32'hAAAA0001);
    i2 = find_data(32'hAAAA0002);
    check("gap_idle_count", i2 - i1 - 1, 2);
    check("gap_idle0", get(i1 + 1), {4'hF, IDLE});
    check("gap_idle1", get(i1 + 2), {4'hF, IDLE});

    // Oversize: 64 words without last, dropped tail, then a good 2-word frame.
    do_reset();
    for (int i = 0; i < 64; i++) send_word(32'h5A000000 + i, 1'b0, 0);
    send_word(32'hDD000000, 1'b0, 0);
    send_word(32'hDD000001, 1'b0, 0);
    send_word(32'hDD000002, 1'b1, 0);
    send_word(32'hBEEF0001, 1'b0, 0);
    send_word(32'hBEEF0002, 1'b1, 0);
    wait_cycles(20);
    check("ovs_err", err_oversize, 1'b1);
    check("ovs_only_good_words", count_data(), 2);
    idx = find_data(32'hBEEF0001);
    check("ovs_w0", get(idx),     {4'h0, 32'hBEEF0001});
    check("ovs_w1", get(idx + 1), {4'h0, 32'hBEEF0002});

    // 8-word frame written with s_valid toggling: transmitted contiguously.
    do_reset();
    for (int i = 0; i < 8; i++) send_word(32'hC0DE0000 + i, i == 7, 1);
    wait_cycles(20);
    idx = find_data(32'hC0DE0000);
    for (int i = 0; i < 8; i++) check("tog_word", get(idx + i), {4'h0, 32'hC0DE0000 + i});
    check("tog_after", get(idx + 8), {4'hF, IDLE});

    // Reset pulsed during word 2 of a 5-word SEND.
    do_reset();
    for (int i = 0; i < 5; i++) send_word(32'hD0000001 + i, i == 4, 0);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (tx_k == 4'h0 && tx_data == 32'hD0000002) found = 1'b1;
    end
    check("mid_w2_seen", found, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_tx_data", tx_data, IDLE);
    check("mid_rst_tx_k", tx_k, 4'hF);
    check("mid_rst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    trace.delete();
    wait_cycles(30);
    check("mid_no_frame_after", count_data(), 0);

    // Statistics: 4 frames, 10 words.
    do_reset();
    send_word(32'hE0000001, 1'b1, 0);
    for (int i = 0; i < 2; i++) send_word(32'hE0000010 + i, i == 1, 0);
    for (int i = 0; i < 3; i++) send_word(32'hE0000020 + i, i == 2, 0);
    for (int i = 0; i < 4; i++) send_word(32'hE0000030 + i, i == 3, 0);
    wait_cycles(80);
    check("stats_frames", frame_cnt, STATS_ON ? 16'd4 : 16'd0);
    check("stats_words", word_cnt, STATS_ON ? 32'd10 : 32'd0);
    check("stats_tx_words", count_data(), 10);

    // Randomized traffic, including exact-fit and oversize frames.
    do_reset();
    for (int f = 0; f < 150; f++) begin
      int r;
      int len;
      r   = int'($urandom_range(0, 39));
      len = (r == 0) ? 64 + int'($urandom_range(1, 6)) :
            (r == 1) ? 64 : int'($urandom_range(1, 10));
      for (int w = 0; w < len; w++)
        send_word($urandom, w == len - 1,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    wait_cycles(150);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hsst_tx_framer_32bit.md
HSST_TX_FRAMER_32BIT -- requirements
Module: hsst_tx_framer_32bit

Interface
- REQ-001: Parameter FIFO_DEPTH, default 64, SHALL set the frame buffer depth in 32-bit words; power of 2, at least 4.
- REQ-002: Parameter MIN_GAP, default 2, SHALL set the minimum number of idle words between frames; range 2..15.
- REQ-003: Port clk, input, 1 bit, SHALL be the clock; all logic on its rising edge.
- REQ-004: Port rstn, input, 1 bit, SHALL be the reset: asynchronous, active-low.
- REQ-005: Port s_valid, input, 1 bit: upstream word valid.
- REQ-006: Port s_ready, output, 1 bit: framer accepts a word; transfer occurs when s_valid and s_ready are both 1.
- REQ-007: Port s_data, input, 32 bits: payload word.
- REQ-008: Port s_last, input, 1 bit: final word of a frame.
- REQ-009: Port tx_data, output, 32 bits: word sent to the HSST transmitter.
- REQ-010: Port tx_k, output, 4 bits: per-byte K flags; bit i marks byte [8i+7:8i].
- REQ-011: Port busy, output, 1 bit: high while the state machine is in SEND.
- REQ-012: Port err_oversize, output, 1 bit: sticky oversize-frame flag.
- REQ-013: Ports frame_cnt (16 bits) and word_cnt (32 bits), outputs, SHALL carry the statistics defined in REQ-031.

Function
- REQ-014: The framer SHALL be store-and-forward; a frame starts transmitting only after its s_last word is written into the buffer.
- REQ-015: s_ready SHALL equal !fifo_full, except during DROP, when s_ready SHALL be 1.
- REQ-016: Each buffer entry SHALL hold {s_last, s_data}, 33 bits.
- REQ-017: The pending-frame counter SHALL increment on each written last word and decrement on each read last word; a simultaneous write and read of last words SHALL leave it unchanged.
- REQ-018: The transmit state machine SHALL have states IDLE, SEND and GAP.
- REQ-019: In IDLE and GAP, the next-cycle outputs SHALL be tx_data=32'hBCBCBCBC and tx_k=4'b1111.
- REQ-020: IDLE -> SEND SHALL occur when pending>0 and gap_cnt>=MIN_GAP; the buffer head is popped in that same cycle.
- REQ-021: In SEND, each cycle SHALL pop one word and register it onto the outputs next cycle with tx_data=word and tx_k=4'b0000.
- REQ-022: The first data word SHALL appear on tx_data exactly 1 cycle after the IDLE->SEND decision; data words SHALL be back-to-back with no idle inside a frame.
- REQ-023: Popping a word with last=1 SHALL move the state to GAP and clear gap_cnt.
- REQ-024: In GAP, gap_cnt SHALL increment once per idle word emitted, saturating at 15.
- REQ-025: GAP -> IDLE SHALL occur when gap_cnt reaches MIN_GAP-1; at least MIN_GAP idle words separate consecutive frames.
- REQ-026: Oversize detection: when the buffer is full and pending==0, the framer SHALL set err_oversize, flush the buffer and enter DROP.
- REQ-027: In DROP, incoming words SHALL be discarded up to and including the next s_last word, after which normal writes resume.
- REQ-028: err_oversize SHALL clear only on reset.

Reset
- REQ-029: On rstn low, the framer SHALL enter IDLE, clear the buffer and pending count, set gap_cnt=0, and drive tx_data=32'hBCBCBCBC, tx_k=4'b1111, busy=0, err_oversize=0 and both statistics outputs to 0.
- REQ-030: A reset asserted mid-frame SHALL discard the partial frame; after release, idles are emitted and no frame starts before MIN_GAP idle words.

Configuration
- REQ-031: With macro HSST_TX_FRAMER_STATS_EN defined, frame_cnt SHALL count transmitted frames and word_cnt SHALL count transmitted data words; both wrap around.
- REQ-032: Without HSST_TX_FRAMER_STATS_EN, frame_cnt and word_cnt SHALL be constant 0 and no counter logic SHALL be synthesized.

Structure
- REQ-033: A shared package SHALL hold the K-code constants (K28_5=8'hBC, IDLE_WORD=32'hBCBCBCBC, TXK_IDLE=4'b1111, TXK_DATA=4'b0000) and the state encoding.
- REQ-034: The buffer SHALL be the sub-module hsst_tx_frame_fifo: synchronous, first-word-fall-through, with full/empty flags and a flush input.

Verification
- REQ-035: A 3-word frame 0x11111111, 0x22222222, 0x33333333 (last) is written after reset -> at least 2 idle words, then the 3 data words back-to-back with tx_k=0000, then idles.
- REQ-036: Two 1-word frames 0xAAAA0001 and 0xAAAA0002 are written back-to-back -> exactly 2 idle words between them when MIN_GAP=2.
- REQ-037: 64 words are written with no s_last (FIFO_DEPTH=64) -> err_oversize=1, buffer flushed, next words discarded through s_last, and a following 2-word frame transmits correctly.
- REQ-038: s_valid is toggled every other cycle during the write of an 8-word frame -> transmission is still contiguous, 8 data cycles with no gaps.
- REQ-039: rstn is pulsed low during word 2 of a 5-word SEND -> tx returns to the idle word immediately and the pending count is 0.
- REQ-040: With HSST_TX_FRAMER_STATS_EN defined and 4 frames totalling 10 words sent -> frame_cnt=4 and word_cnt=10; without the macro, both read 0.
